// File: rtl/instr_cache.sv
// Direct-mapped read-only L1 instruction cache with a 32-bit AXI3 refill port.
// A hit returns its word one cycle after the request; a miss refills a whole 16-word line.
module instr_cache #(
    parameter int unsigned SETS       = 64,
    parameter int unsigned LINE_WORDS = 16
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_addr_ready,
    input  logic        io_addr_valid,
    input  logic [31:0] io_addr_bits,
    output logic        io_data_valid,
    output logic [31:0] io_data_bits,
    input  logic        io_flush,
    input  logic        io_axi_ar_ready,
    output logic        io_axi_ar_valid,
    output logic [3:0]  io_axi_ar_bits_id,
    output logic [31:0] io_axi_ar_bits_addr,
    output logic [3:0]  io_axi_ar_bits_len,
    output logic [2:0]  io_axi_ar_bits_size,
    output logic [1:0]  io_axi_ar_bits_burst,
    output logic [1:0]  io_axi_ar_bits_lock,
    output logic [3:0]  io_axi_ar_bits_cache,
    output logic [2:0]  io_axi_ar_bits_prot,
    output logic        io_axi_r_ready,
    input  logic        io_axi_r_valid,
    input  logic [3:0]  io_axi_r_bits_id,
    input  logic [31:0] io_axi_r_bits_data,
    input  logic [1:0]  io_axi_r_bits_resp,
    input  logic        io_axi_r_bits_last,
    input  logic        io_axi_aw_ready,
    output logic        io_axi_aw_valid,
    output logic [3:0]  io_axi_aw_bits_id,
    output logic [31:0] io_axi_aw_bits_addr,
    output logic [3:0]  io_axi_aw_bits_len,
    output logic [2:0]  io_axi_aw_bits_size,
    output logic [1:0]  io_axi_aw_bits_burst,
    output logic [1:0]  io_axi_aw_bits_lock,
    output logic [3:0]  io_axi_aw_bits_cache,
    output logic [2:0]  io_axi_aw_bits_prot,
    input  logic        io_axi_w_ready,
    output logic        io_axi_w_valid,
    output logic [3:0]  io_axi_w_bits_id,
    output logic [31:0] io_axi_w_bits_data,
    output logic [3:0]  io_axi_w_bits_strb,
    output logic        io_axi_w_bits_last,
    output logic        io_axi_b_ready,
    input  logic        io_axi_b_valid,
    input  logic [3:0]  io_axi_b_bits_id,
    input  logic [1:0]  io_axi_b_bits_resp
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 32 - 6 - IDX_W;

    typedef enum logic [1:0] {S_LOOKUP, S_AR, S_REFILL, S_DONE} state_t;

    state_t            state;
    logic              req_valid;
    logic [31:0]       req_addr;
    logic              killed;
    logic              pend_valid;
    logic [31:0]       pend_addr;
    logic [3:0]        beat;
    logic [SETS-1:0]   line_valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [31:0]       data [SETS][LINE_WORDS];

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [3:0]        req_word;
    logic              hit;
    logic              lookup_miss;
    logic              addr_fire;
    logic              r_fire;
    logic              unused;

    assign req_idx  = req_addr[6 +: IDX_W];
    assign req_tag  = req_addr[31 -: TAG_W];
    assign req_word = req_addr[5:2];
    assign hit         = req_valid && line_valid[req_idx] && (tags[req_idx] == req_tag);
    assign lookup_miss = (state == S_LOOKUP) && req_valid && !hit;

    // Ready drops only on an unflushed miss or in the install cycle; a flush reopens it for the redirect.
    assign io_addr_ready = ((state == S_LOOKUP) && (!lookup_miss || io_flush)) ||
                           (((state == S_AR) || (state == S_REFILL)) && io_flush);
    assign io_data_valid = !io_flush &&
                           (((state == S_LOOKUP) && hit) || ((state == S_DONE) && !killed));
    assign io_data_bits  = io_data_valid ? data[req_idx][req_word] : 32'h0;
    assign addr_fire     = io_addr_valid && io_addr_ready;
    assign r_fire        = io_axi_r_valid && io_axi_r_ready;

    assign io_axi_ar_valid      = (state == S_AR);
    assign io_axi_ar_bits_id    = 4'd0;
    assign io_axi_ar_bits_addr  = {req_addr[31:6], 6'b0};
    assign io_axi_ar_bits_len   = 4'd15;
    assign io_axi_ar_bits_size  = 3'd2;
    assign io_axi_ar_bits_burst = 2'd1;
    assign io_axi_ar_bits_lock  = 2'd0;
    assign io_axi_ar_bits_cache = 4'd0;
    assign io_axi_ar_bits_prot  = 3'd0;
    assign io_axi_r_ready       = (state == S_REFILL);

    assign io_axi_aw_valid      = 1'b0;
    assign io_axi_aw_bits_id    = 4'd0;
    assign io_axi_aw_bits_addr  = 32'd0;
    assign io_axi_aw_bits_len   = 4'd0;
    assign io_axi_aw_bits_size  = 3'd0;
    assign io_axi_aw_bits_burst = 2'd0;
    assign io_axi_aw_bits_lock  = 2'd0;
    assign io_axi_aw_bits_cache = 4'd0;
    assign io_axi_aw_bits_prot  = 3'd0;
    assign io_axi_w_valid       = 1'b0;
    assign io_axi_w_bits_id     = 4'd0;
    assign io_axi_w_bits_data   = 32'd0;
    assign io_axi_w_bits_strb   = 4'd0;
    assign io_axi_w_bits_last   = 1'b0;
    assign io_axi_b_ready       = 1'b0;

    assign unused = ^{io_axi_aw_ready, io_axi_w_ready, io_axi_b_valid, io_axi_b_bits_id,
                      io_axi_b_bits_resp, io_axi_r_bits_id, io_axi_r_bits_resp, req_addr[1:0]};

    // Control state machine and request bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_LOOKUP;
            req_valid  <= 1'b0;
            req_addr   <= 32'h0;
            killed     <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= 32'h0;
            beat       <= 4'd0;
            line_valid <= '0;
        end else begin
            case (state)
                S_LOOKUP: begin
                    if (lookup_miss && !io_flush) begin
                        state  <= S_AR;
                        killed <= 1'b0;
                        beat   <= 4'd0;
                    end else begin
                        req_valid <= addr_fire;
                        if (addr_fire) req_addr <= io_addr_bits;
                    end
                end
                S_AR: begin
                    if (io_axi_ar_ready) state <= S_REFILL;
                end
                S_REFILL: begin
                    if (r_fire) begin
                        beat <= beat + 4'd1;
                        if (io_axi_r_bits_last) begin
                            line_valid[req_idx] <= 1'b1;
                            state               <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state      <= S_LOOKUP;
                    req_valid  <= pend_valid && !io_flush;
                    if (pend_valid) req_addr <= pend_addr;
                    pend_valid <= 1'b0;
                end
                default: state <= S_LOOKUP;
            endcase
            // The burst always completes; a flush only kills the original and stages the redirect.
            if (((state == S_AR) || (state == S_REFILL)) && io_flush) begin
                killed     <= 1'b1;
                pend_valid <= io_addr_valid;
                if (io_addr_valid) pend_addr <= io_addr_bits;
            end
        end
    end

    // Line storage; contents are only trusted once the valid bit is set.
    always_ff @(posedge clock) begin
        if (!reset && (state == S_REFILL) && r_fire) begin
            data[req_idx][beat] <= io_axi_r_bits_data;
            if (io_axi_r_bits_last) tags[req_idx] <= req_tag;
        end
    end
endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: refills, hit stream, conflict miss, flushes and mid-refill reset.
module tb_instr_cache;
    logic        clock = 1'b0;
    logic        reset;
    logic        io_addr_ready;
    logic        io_addr_valid;
    logic [31:0] io_addr_bits;
    logic        io_data_valid;
    logic [31:0] io_data_bits;
    logic        io_flush;
    logic        io_axi_ar_ready;
    logic        io_axi_ar_valid;
    logic [3:0]  io_axi_ar_bits_id;
    logic [31:0] io_axi_ar_bits_addr;
    logic [3:0]  io_axi_ar_bits_len;
    logic [2:0]  io_axi_ar_bits_size;
    logic [1:0]  io_axi_ar_bits_burst;
    logic [1:0]  io_axi_ar_bits_lock;
    logic [3:0]  io_axi_ar_bits_cache;
    logic [2:0]  io_axi_ar_bits_prot;
    logic        io_axi_r_ready;
    logic        io_axi_r_valid;
    logic [3:0]  io_axi_r_bits_id;
    logic [31:0] io_axi_r_bits_data;
    logic [1:0]  io_axi_r_bits_resp;
    logic        io_axi_r_bits_last;
    logic        io_axi_aw_ready;
    logic        io_axi_aw_valid;
    logic [3:0]  io_axi_aw_bits_id;
    logic [31:0] io_axi_aw_bits_addr;
    logic [3:0]  io_axi_aw_bits_len;
    logic [2:0]  io_axi_aw_bits_size;
    logic [1:0]  io_axi_aw_bits_burst;
    logic [1:0]  io_axi_aw_bits_lock;
    logic [3:0]  io_axi_aw_bits_cache;
    logic [2:0]  io_axi_aw_bits_prot;
    logic        io_axi_w_ready;
    logic        io_axi_w_valid;
    logic [3:0]  io_axi_w_bits_id;
    logic [31:0] io_axi_w_bits_data;
    logic [3:0]  io_axi_w_bits_strb;
    logic        io_axi_w_bits_last;
    logic        io_axi_b_ready;
    logic        io_axi_b_valid;
    logic [3:0]  io_axi_b_bits_id;
    logic [1:0]  io_axi_b_bits_resp;

    int total = 0;
    int bad   = 0;

    instr_cache dut (
        .clock(clock), .reset(reset),
        .io_addr_ready(io_addr_ready), .io_addr_valid(io_addr_valid), .io_addr_bits(io_addr_bits),
        .io_data_valid(io_data_valid), .io_data_bits(io_data_bits), .io_flush(io_flush),
        .io_axi_ar_ready(io_axi_ar_ready), .io_axi_ar_valid(io_axi_ar_valid),
        .io_axi_ar_bits_id(io_axi_ar_bits_id), .io_axi_ar_bits_addr(io_axi_ar_bits_addr),
        .io_axi_ar_bits_len(io_axi_ar_bits_len), .io_axi_ar_bits_size(io_axi_ar_bits_size),
        .io_axi_ar_bits_burst(io_axi_ar_bits_burst), .io_axi_ar_bits_lock(io_axi_ar_bits_lock),
        .io_axi_ar_bits_cache(io_axi_ar_bits_cache), .io_axi_ar_bits_prot(io_axi_ar_bits_prot),
        .io_axi_r_ready(io_axi_r_ready), .io_axi_r_valid(io_axi_r_valid),
        .io_axi_r_bits_id(io_axi_r_bits_id), .io_axi_r_bits_data(io_axi_r_bits_data),
        .io_axi_r_bits_resp(io_axi_r_bits_resp), .io_axi_r_bits_last(io_axi_r_bits_last),
        .io_axi_aw_ready(io_axi_aw_ready), .io_axi_aw_valid(io_axi_aw_valid),
        .io_axi_aw_bits_id(io_axi_aw_bits_id), .io_axi_aw_bits_addr(io_axi_aw_bits_addr),
        .io_axi_aw_bits_len(io_axi_aw_bits_len), .io_axi_aw_bits_size(io_axi_aw_bits_size),
        .io_axi_aw_bits_burst(io_axi_aw_bits_burst), .io_axi_aw_bits_lock(io_axi_aw_bits_lock),
        .io_axi_aw_bits_cache(io_axi_aw_bits_cache), .io_axi_aw_bits_prot(io_axi_aw_bits_prot),
        .io_axi_w_ready(io_axi_w_ready), .io_axi_w_valid(io_axi_w_valid),
        .io_axi_w_bits_id(io_axi_w_bits_id), .io_axi_w_bits_data(io_axi_w_bits_data),
        .io_axi_w_bits_strb(io_axi_w_bits_strb), .io_axi_w_bits_last(io_axi_w_bits_last),
        .io_axi_b_ready(io_axi_b_ready), .io_axi_b_valid(io_axi_b_valid),
        .io_axi_b_bits_id(io_axi_b_bits_id), .io_axi_b_bits_resp(io_axi_b_bits_resp)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at the AR cycle; leaves the bench at the start of the install (DONE) cycle.
    task automatic do_refill(input logic [31:0] line, input logic [31:0] dbase,
                             input int flush_beat, input logic [31:0] redirect);
        io_axi_ar_ready = 1'b1;
        settle();
        chk("ar_valid", 32'(io_axi_ar_valid), 32'h1);
        chk("ar_addr", io_axi_ar_bits_addr, line);
        chk("ar_len", 32'(io_axi_ar_bits_len), 32'd15);
        chk("ar_size", 32'(io_axi_ar_bits_size), 32'd2);
        chk("ar_burst", 32'(io_axi_ar_bits_burst), 32'd1);
        cyc();
        io_axi_ar_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            io_axi_r_valid     = 1'b1;
            io_axi_r_bits_data = dbase + 32'(k);
            io_axi_r_bits_last = (k == 15);
            if (k == flush_beat) begin
                io_flush      = 1'b1;
                io_addr_valid = 1'b1;
                io_addr_bits  = redirect;
            end
            settle();
            chk("r_ready", 32'(io_axi_r_ready), 32'h1);
            if (k == flush_beat) begin
                chk("refill_flush_ready", 32'(io_addr_ready), 32'h1);
                chk("refill_flush_dv", 32'(io_data_valid), 32'h0);
            end
            cyc();
            io_flush      = 1'b0;
            io_addr_valid = 1'b0;
        end
        io_axi_r_valid     = 1'b0;
        io_axi_r_bits_last = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        io_addr_valid = 1'b0; io_addr_bits = 32'h0; io_flush = 1'b0;
        io_axi_ar_ready = 1'b0; io_axi_r_valid = 1'b0; io_axi_r_bits_id = 4'h0;
        io_axi_r_bits_data = 32'h0; io_axi_r_bits_resp = 2'h0; io_axi_r_bits_last = 1'b0;
        io_axi_aw_ready = 1'b1; io_axi_w_ready = 1'b1; io_axi_b_valid = 1'b0;
        io_axi_b_bits_id = 4'h0; io_axi_b_bits_resp = 2'h0;
        repeat (2) cyc();
        reset = 1'b0;
        settle();
        chk("rst_ready", 32'(io_addr_ready), 32'h1);
        chk("rst_dv", 32'(io_data_valid), 32'h0);
        chk("rst_data", io_data_bits, 32'h0);
        chk("rst_ar_valid", 32'(io_axi_ar_valid), 32'h0);
        chk("rst_r_ready", 32'(io_axi_r_ready), 32'h0);
        chk("aw_w_b_tied", {29'h0, io_axi_aw_valid, io_axi_w_valid, io_axi_b_ready}, 32'h0);

        // Cold miss on 0x1044: word 1 of the line at 0x1040.
        cyc(); io_addr_valid = 1'b1; io_addr_bits = 32'h0000_1044; settle();
        chk("cold_accept_ready", 32'(io_addr_ready), 32'h1);
        cyc(); io_addr_valid = 1'b0; settle();
        chk("cold_miss_ready", 32'(io_addr_ready), 32'h0);
        chk("cold_miss_dv", 32'(io_data_valid), 32'h0);
        cyc();
        do_refill(32'h0000_1040, 32'h100, -1, 32'h0);
        settle();
        chk("cold_done_dv", 32'(io_data_valid), 32'h1);
        chk("cold_done_data", io_data_bits, 32'h101);
        chk("cold_done_ready", 32'(io_addr_ready), 32'h0);

        // Back-to-back hits over the whole line.
        cyc(); io_addr_valid = 1'b1; io_addr_bits = 32'h0000_1040; settle();
        chk("post_done_dv", 32'(io_data_valid), 32'h0);
        chk("post_done_ready", 32'(io_addr_ready), 32'h1);
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (i < 16) io_addr_bits = 32'h0000_1040 + 32'(4 * i);
            else io_addr_valid = 1'b0;
            settle();
            chk("hit_dv", 32'(io_data_valid), 32'h1);
            chk("hit_data", io_data_bits, 32'h100 + 32'(i - 1));
            chk("hit_ready", 32'(io_addr_ready), 32'h1);
        end
        cyc(); settle();
        chk("idle_dv", 32'(io_data_valid), 32'h0);

        // Conflict miss: 0x2040 shares the set with 0x1040.
        io_addr_valid = 1'b1; io_addr_bits = 32'h0000_2040;
        cyc(); io_addr_valid = 1'b0; settle();
        chk("conflict_miss_ready", 32'(io_addr_ready), 32'h0);
        cyc();
        do_refill(32'h0000_2040, 32'h200, -1, 32'h0);
        settle();
        chk("conflict_done_data", io_data_bits, 32'h200);
        cyc(); io_addr_valid = 1'b1; io_addr_bits = 32'h0000_1040;
        cyc(); io_addr_valid = 1'b0; settle();
        chk("evicted_miss_dv", 32'(io_data_valid), 32'h0);
        chk("evicted_miss_ready", 32'(io_addr_ready), 32'h0);
        cyc();
        do_refill(32'h0000_1040, 32'h100, -1, 32'h0);
        settle();
        chk("refetch_done_data", io_data_bits, 32'h100);

        // Flush on a hit cycle suppresses the data.
        cyc(); io_addr_valid = 1'b1; io_addr_bits = 32'h0000_1040;
        cyc(); io_addr_valid = 1'b0; io_flush = 1'b1; settle();
        chk("flush_hit_dv", 32'(io_data_valid), 32'h0);
        chk("flush_hit_ready", 32'(io_addr_ready), 32'h1);
        cyc(); io_flush = 1'b0;

        // Flush on a miss cycle drops the request: no burst follows.
        io_addr_valid = 1'b1; io_addr_bits = 32'h0000_4000;
        cyc(); io_addr_valid = 1'b0; io_flush = 1'b1; settle();
        chk("flush_miss_ready", 32'(io_addr_ready), 32'h1);
        chk("flush_miss_dv", 32'(io_data_valid), 32'h0);
        cyc(); io_flush = 1'b0; settle();
        chk("flush_miss_no_ar", 32'(io_axi_ar_valid), 32'h0);
        chk("flush_miss_ready_after", 32'(io_addr_ready), 32'h1);

        // Flush during refill with redirect to 0x1048.
        io_addr_valid = 1'b1; io_addr_bits = 32'h0000_3000;
        cyc(); io_addr_valid = 1'b0; settle();
        chk("redir_miss_ready", 32'(io_addr_ready), 32'h0);
        cyc();
        do_refill(32'h0000_3000, 32'h300, 3, 32'h0000_1048);
        settle();
        chk("killed_done_dv", 32'(io_data_valid), 32'h0);
        chk("killed_done_ready", 32'(io_addr_ready), 32'h0);
        cyc(); settle();
        chk("redirect_dv", 32'(io_data_valid), 32'h1);
        chk("redirect_data", io_data_bits, 32'h102);

        // Reset in the middle of a refill (beat 7).
        cyc(); io_addr_valid = 1'b1; io_addr_bits = 32'h0000_5000;
        cyc(); io_addr_valid = 1'b0;
        cyc(); io_axi_ar_ready = 1'b1; settle();
        chk("rst_test_ar_valid", 32'(io_axi_ar_valid), 32'h1);
        cyc(); io_axi_ar_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            io_axi_r_valid = 1'b1; io_axi_r_bits_data = 32'h500 + 32'(k);
            cyc();
        end
        reset = 1'b1; io_axi_r_bits_data = 32'h507;
        cyc(); reset = 1'b0; settle();
        chk("midrst_ar_valid", 32'(io_axi_ar_valid), 32'h0);
        chk("midrst_r_ready", 32'(io_axi_r_ready), 32'h0);
        chk("midrst_dv", 32'(io_data_valid), 32'h0);
        chk("midrst_ready", 32'(io_addr_ready), 32'h1);
        io_axi_r_valid = 1'b0;
        io_addr_valid = 1'b1; io_addr_bits = 32'h0000_1040;
        cyc(); io_addr_valid = 1'b0; settle();
        chk("midrst_invalid_dv", 32'(io_data_valid), 32'h0);
        chk("midrst_invalid_ready", 32'(io_addr_ready), 32'h0);
        cyc(); settle();
        chk("midrst_refetch_ar", 32'(io_axi_ar_valid), 32'h1);
        chk("midrst_refetch_addr", io_axi_ar_bits_addr, 32'h0000_1040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
